// File: rtl/max7219_pkg.sv
// Shared MAX7219 definitions: register address map, receive FSM encoding and
// the debug view exported by the responder.
package max7219_pkg;

    localparam logic [3:0] REG_NOOP      = 4'h0;
    localparam logic [3:0] REG_DIGIT0    = 4'h1;
    localparam logic [3:0] REG_DIGIT1    = 4'h2;
    localparam logic [3:0] REG_DIGIT2    = 4'h3;
    localparam logic [3:0] REG_DIGIT3    = 4'h4;
    localparam logic [3:0] REG_DIGIT4    = 4'h5;
    localparam logic [3:0] REG_DIGIT5    = 4'h6;
    localparam logic [3:0] REG_DIGIT6    = 4'h7;
    localparam logic [3:0] REG_DIGIT7    = 4'h8;
    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIM   = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;

    localparam logic [4:0] FRAME_BITS = 5'd16;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_SHIFT  = 2'd1,
        RX_COMMIT = 2'd2
    } rx_state_t;

    typedef struct packed {
        rx_state_t  state;
        logic [4:0] bit_cnt;
        logic [7:0] decode;
        logic [2:0] scan_limit;
        logic       shutdown_n;
        logic       test;
        logic       sclk_level;
        logic       sclk_fall;
        logic       ncs_level;
    } rx_debug_t;

endpackage

// File: rtl/max7219_rx_model_if.sv
// Serial link of one MAX7219: the controller drives din/sclk/ncs, the device drives dout.
// No handshake: the link is a plain SPI-like stream, framed by ncs low and latched on its rise.
interface max7219_rx_model_if;
    logic din;
    logic sclk;
    logic ncs;
    logic dout;

    modport master (output din, output sclk, output ncs, input dout);
    modport slave  (input din, input sclk, input ncs, output dout);
endinterface

// File: rtl/max7219_rx_model_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous pin followed by one history
// register that yields single-cycle rise/fall pulses.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], sig};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/max7219_rx_model.sv
// MAX7219-compatible responder: oversamples the serial link, decodes 16-bit write
// frames into the register file and exposes the effective displayed rows.
module max7219_rx_model
    import max7219_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter bit RST_SHUTDOWN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    max7219_rx_model_if.slave   link,
    input  logic [2:0]          rd_addr,
    output logic [7:0]          rd_data,
    output logic [3:0]          intensity,
    output logic                frame_done,
    output logic                frame_err,
    output rx_debug_t           dbg
);
    logic sclk_level, sclk_rise, sclk_fall;
    logic ncs_level, ncs_rise, ncs_fall;
    logic [SYNC_STAGES-1:0] din_chain;
    logic din_s;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .reset(reset), .sig(link.sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_ncs (
        .clk(clk), .reset(reset), .sig(link.ncs),
        .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
    );

    // din goes through the same depth so it lines up with the sclk level it was sampled with
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) din_chain <= '0;
        else        din_chain <= {din_chain[SYNC_STAGES-2:0], link.din};
    end
    assign din_s = din_chain[SYNC_STAGES-1];

    rx_state_t   state, state_next;
    logic        shift_en, cnt_clr;
    logic [15:0] sreg;
    logic [4:0]  bit_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RX_IDLE;
        else        state <= state_next;
    end

    // An ncs rise in the same sampled cycle as an sclk rise closes the frame without shifting
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        cnt_clr    = 1'b0;
        case (state)
            RX_IDLE: begin
                shift_en = sclk_rise;
                if (ncs_fall) begin
                    state_next = RX_SHIFT;
                    cnt_clr    = 1'b1;
                end
            end
            RX_SHIFT: begin
                if (ncs_rise) state_next = RX_COMMIT;
                else          shift_en   = sclk_rise;
            end
            RX_COMMIT: begin
                shift_en   = sclk_rise;
                state_next = RX_IDLE;
            end
            default: state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else begin
            if (shift_en) sreg <= {sreg[14:0], din_s};
            if (cnt_clr)
                bit_cnt <= '0;
            else if (state == RX_SHIFT && shift_en && bit_cnt != FRAME_BITS)
                bit_cnt <= bit_cnt + 5'd1;
        end
    end

    assign link.dout = sreg[15];

    logic       commit_ok;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] wr_idx;
    logic [7:0] digit [8];
    logic [7:0] decode;
    logic [2:0] scan_limit;
    logic       shutdown_n;
    logic       test;

    assign commit_ok = (state == RX_COMMIT) && (bit_cnt == FRAME_BITS);
    assign frame_err = (state == RX_COMMIT) && (bit_cnt != FRAME_BITS);
    assign wr_addr   = sreg[11:8];
    assign wr_data   = sreg[7:0];
    // Digit registers 1..8 map to rows 0..7; address 8 wraps to row 7 in three bits
    assign wr_idx    = wr_addr[2:0] - 3'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) digit[i] <= '0;
            decode     <= '0;
            intensity  <= '0;
            scan_limit <= '0;
            shutdown_n <= ~RST_SHUTDOWN;
            test       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= commit_ok && (wr_addr == REG_DIGIT7);
            if (commit_ok) begin
                case (wr_addr)
                    REG_DIGIT0, REG_DIGIT1, REG_DIGIT2, REG_DIGIT3,
                    REG_DIGIT4, REG_DIGIT5, REG_DIGIT6, REG_DIGIT7:
                                   digit[wr_idx] <= wr_data;
                    REG_DECODE:    decode        <= wr_data;
                    REG_INTENSITY: intensity     <= wr_data[3:0];
                    REG_SCANLIM:   scan_limit    <= wr_data[2:0];
                    REG_SHUTDOWN:  shutdown_n    <= wr_data[0];
                    REG_TEST:      test          <= wr_data[0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = digit[rd_addr];
        if (test)                      rd_data = 8'hFF;
        else if (!shutdown_n)          rd_data = 8'h00;
        else if (rd_addr > scan_limit) rd_data = 8'h00;
    end

    always_comb begin
        dbg            = '0;
        dbg.state      = state;
        dbg.bit_cnt    = bit_cnt;
        dbg.decode     = decode;
        dbg.scan_limit = scan_limit;
        dbg.shutdown_n = shutdown_n;
        dbg.test       = test;
        dbg.sclk_level = sclk_level;
        dbg.sclk_fall  = sclk_fall;
        dbg.ncs_level  = ncs_level;
    end
endmodule

// File: tb/tb_max7219_rx_model.sv
// Bench for max7219_rx_model: directed and random serial frames checked against
// a register-level model of the device kept here.
module tb_max7219_rx_model;
    import max7219_pkg::*;

    logic       clk;
    logic       reset;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic [3:0] intensity;
    logic       frame_done;
    logic       frame_err;
    rx_debug_t  dbg;

    max7219_rx_model_if link();

    max7219_rx_model #(.SYNC_STAGES(2), .RST_SHUTDOWN(1'b1)) dut (
        .clk(clk), .reset(reset), .link(link),
        .rd_addr(rd_addr), .rd_data(rd_data), .intensity(intensity),
        .frame_done(frame_done), .frame_err(frame_err), .dbg(dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err  = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (frame_done) n_done++;
            if (frame_err)  n_err++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: device registers plus every bit ever clocked into the shift path
    logic [7:0]  m_digit [8];
    logic [7:0]  m_decode;
    logic [3:0]  m_int;
    logic [2:0]  m_scan;
    logic        m_shut;
    logic        m_test;
    logic        hist_q[$];
    logic [15:0] exp_q[$];

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
        m_decode = 8'h00;
        m_int    = 4'h0;
        m_scan   = 3'd0;
        m_shut   = 1'b0;
        m_test   = 1'b0;
        hist_q.delete();
        exp_q.delete();
    endfunction

    function automatic void model_apply(input logic [15:0] word);
        int a;
        a = int'(word[11:8]);
        if (a >= 1 && a <= 8) m_digit[a-1] = word[7:0];
        else if (a == 9)  m_decode = word[7:0];
        else if (a == 10) m_int    = word[3:0];
        else if (a == 11) m_scan   = word[2:0];
        else if (a == 12) m_shut   = word[0];
        else if (a == 15) m_test   = word[0];
    endfunction

    function automatic logic [7:0] model_row(input int r);
        if (m_test)          return 8'hFF;
        if (!m_shut)         return 8'h00;
        if (r > int'(m_scan)) return 8'h00;
        return m_digit[r];
    endfunction

    function automatic logic model_dout();
        if (hist_q.size() < 16) return 1'b0;
        return hist_q[hist_q.size() - 16];
    endfunction

    // driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        link.din = b;
        wait_cyc(2);
        link.sclk = 1'b1;
        hist_q.push_back(b);
        wait_cyc(5);
        link.sclk = 1'b0;
        wait_cyc(4);
        check("dout", link.dout, model_dout());
    endtask

    task automatic frame_close(input int nbits, input logic [15:0] last16);
        int d0, e0;
        d0 = n_done;
        e0 = n_err;
        link.ncs = 1'b1;
        wait_cyc(8);
        if (nbits >= 16) begin
            exp_q.push_back(last16);
            model_apply(exp_q.pop_front());
        end
        check("frame_err", n_err - e0, (nbits < 16) ? 1 : 0);
        check("frame_done", n_done - d0, (nbits >= 16 && last16[11:8] == 4'h8) ? 1 : 0);
        check("state_idle", dbg.state, RX_IDLE);
    endtask

    task automatic send_frame(input logic [31:0] bits, input int nbits);
        link.ncs = 1'b0;
        wait_cyc(4);
        for (int i = nbits - 1; i >= 0; i--) shift_bit(bits[i]);
        frame_close(nbits, bits[15:0]);
    endtask

    // 16 bits, then sclk and ncs rise together: the extra bit must not land
    task automatic send_frame_collide(input logic [15:0] word);
        int d0;
        link.ncs = 1'b0;
        wait_cyc(4);
        for (int i = 15; i >= 0; i--) shift_bit(word[i]);
        d0 = n_done;
        link.din = ~word[0];
        wait_cyc(2);
        link.sclk = 1'b1;
        link.ncs  = 1'b1;
        wait_cyc(5);
        link.sclk = 1'b0;
        wait_cyc(6);
        model_apply(word);
        check("collide_dout", link.dout, model_dout());
        check("collide_done", n_done - d0, (word[11:8] == 4'h8) ? 1 : 0);
    endtask

    task automatic check_all();
        for (int r = 0; r < 8; r++) begin
            rd_addr = 3'(r);
            #1;
            check($sformatf("row%0d", r), rd_data, model_row(r));
        end
        check("intensity", intensity, m_int);
        check("scan_limit", dbg.scan_limit, m_scan);
        check("shutdown_n", dbg.shutdown_n, m_shut);
        check("test", dbg.test, m_test);
        check("decode", dbg.decode, m_decode);
    endtask

    logic [7:0] pattern [8];

    initial begin
        pattern[0] = 8'h3C; pattern[1] = 8'h42; pattern[2] = 8'h81; pattern[3] = 8'hA5;
        pattern[4] = 8'h99; pattern[5] = 8'h24; pattern[6] = 8'h18; pattern[7] = 8'hFF;

        reset     = 1'b0;
        link.din  = 1'b0;
        link.sclk = 1'b0;
        link.ncs  = 1'b1;
        rd_addr   = 3'd0;
        model_reset();
        wait_cyc(4);
        check("reset_dout", link.dout, 1'b0);
        check("reset_frame_done", frame_done, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        reset = 1'b1;
        wait_cyc(6);
        check_all();

        // wake up; all rows still blank since digits are zero
        send_frame(32'h0C01, 16);
        check_all();

        send_frame(32'h0B07, 16);
        for (int i = 0; i < 8; i++)
            send_frame({16'h0, 4'h0, 4'(i + 1), pattern[i]}, 16);
        check_all();

        send_frame(32'h0B02, 16);
        check_all();

        send_frame(32'h0F01, 16);
        check_all();
        send_frame(32'h0F00, 16);
        check_all();
        send_frame(32'h0C00, 16);
        check_all();
        send_frame(32'h0C01, 16);
        send_frame(32'h0B07, 16);

        send_frame(32'h0ABC, 12);
        check_all();
        send_frame(32'hFF0A05, 24);
        check("intensity_24b", intensity, 4'h5);
        check_all();

        // bits clocked with ncs high shift through but never commit
        for (int i = 0; i < 5; i++) shift_bit(1'($urandom_range(0, 1)));
        check_all();

        send_frame_collide(16'h0A09);
        check_all();

        for (int k = 0; k < 30; k++) begin
            int n;
            n = $urandom_range(12, 24);
            send_frame($urandom, n);
            check_all();
        end

        // reset mid-frame: partial frame must leave nothing behind
        link.ncs = 1'b0;
        wait_cyc(4);
        for (int i = 0; i < 8; i++) shift_bit(1'($urandom_range(0, 1)));
        reset = 1'b0;
        wait_cyc(3);
        link.ncs = 1'b1;
        link.din = 1'b0;
        model_reset();
        wait_cyc(3);
        check("midreset_dout", link.dout, 1'b0);
        reset = 1'b1;
        wait_cyc(6);
        check("midreset_state", dbg.state, RX_IDLE);
        check_all();

        // full scan after recovery mirrors random row data
        send_frame(32'h0C01, 16);
        send_frame(32'h0B07, 16);
        send_frame(32'h0F00, 16);
        for (int i = 0; i < 8; i++)
            send_frame({16'h0, 4'h0, 4'(i + 1), 8'($urandom)}, 16);
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
